// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the bubble instruction and the PC word-index width helper.
package fetch_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Number of PC bits needed to index a memory of 'depth' words.
  function automatic int fetch_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. bubble wins over load; neither means hold.
// A bubble clears the instruction to NOP, drops valid, and zeroes pc_next.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_next_in,
  output logic [31:0] instr,
  output logic [31:0] pc_next,
  output logic        valid
);

  // Register update: reset > bubble > load > hold.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      instr   <= NOP_INSTR;
      pc_next <= 32'h0;
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= instr_in;
      pc_next <= pc_next_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the BOOT/RUN/HALT sequencing and
// feeds the IF/ID register. Optional perf counters under `FETCH_PERF_EN`.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          MEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc,
  input  logic [31:0] i_instruction,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc_next,
  output logic        o_ifid_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_stall_count,
`endif
  output logic        o_halted
);

  localparam int AW = fetch_addr_w(MEM_DEPTH);

  logic [1:0]  state, state_nxt;
  logic [31:0] pc_nxt, pc_plus1, tgt;
  logic        halted_nxt, ifid_load, ifid_bubble;
  logic        unused_tgt_hi;

  assign pc_plus1      = o_pc + 32'd1;
  // Redirect targets wrap modulo the memory depth.
  assign tgt           = 32'(i_branch_target[AW-1:0]);
  assign unused_tgt_hi = ^i_branch_target[31:AW];

  // Next PC, state, halt flag and IF/ID controls; branch > stall > advance.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = o_pc;
    halted_nxt  = o_halted;
    ifid_load   = 1'b0;
    ifid_bubble = i_flush;
    case (state)
      ST_BOOT: begin
        ifid_bubble = 1'b1;
        state_nxt   = ST_RUN;
      end
      ST_RUN: begin
        if (i_branch_taken) begin
          pc_nxt      = tgt;
          ifid_bubble = 1'b1;
        end else if (!i_stall) begin
          ifid_load = 1'b1;
          if (o_pc == 32'(MEM_DEPTH - 1)) begin
            // Last word: capture it but park the PC rather than increment.
            state_nxt  = ST_HALT;
            halted_nxt = 1'b1;
          end else begin
            pc_nxt = pc_plus1;
          end
        end
      end
      ST_HALT: begin
        ifid_bubble = 1'b1;
        if (i_branch_taken) begin
          pc_nxt     = tgt;
          halted_nxt = 1'b0;
          state_nxt  = ST_RUN;
        end
      end
      default: begin
        ifid_bubble = 1'b1;
        state_nxt   = ST_BOOT;
      end
    endcase
  end

  // PC, FSM state and halt flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_pc     <= RESET_PC;
      state    <= ST_BOOT;
      o_halted <= 1'b0;
    end else begin
      o_pc     <= pc_nxt;
      state    <= state_nxt;
      o_halted <= halted_nxt;
    end
  end

  ifid_reg u_ifid (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .instr_in   (i_instruction),
    .pc_next_in (pc_plus1),
    .instr      (o_ifid_instr),
    .pc_next    (o_ifid_pc_next),
    .valid      (o_ifid_valid)
  );

`ifdef FETCH_PERF_EN
  // Saturating counters: valid loads into IF/ID and non-redirected stall edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_fetch_count <= 32'h0;
      o_stall_count <= 32'h0;
    end else begin
      if (ifid_load && !ifid_bubble && o_fetch_count != 32'hFFFF_FFFF)
        o_fetch_count <= o_fetch_count + 32'd1;
      if (i_stall && !i_branch_taken && o_stall_count != 32'hFFFF_FFFF)
        o_stall_count <= o_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a transaction-level
// model of the fetch rules. Build with +define+FETCH_PERF_EN to cover counters.
module tb_fetch_stage;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset, i_stall, i_flush, i_branch_taken;
  logic [31:0] i_branch_target, o_pc, i_instruction;
  logic [31:0] o_ifid_instr, o_ifid_pc_next;
  logic        o_ifid_valid, o_halted;
`ifdef FETCH_PERF_EN
  logic [31:0] o_fetch_count, o_stall_count;
`endif

  logic [31:0] mem [DEPTH];
  assign i_instruction = mem[o_pc[4:0]];

  always #5 clk = ~clk;

  fetch_stage #(.MEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .i_stall(i_stall), .i_flush(i_flush),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .o_pc(o_pc), .i_instruction(i_instruction),
    .o_ifid_instr(o_ifid_instr), .o_ifid_pc_next(o_ifid_pc_next),
    .o_ifid_valid(o_ifid_valid),
`ifdef FETCH_PERF_EN
    .o_fetch_count(o_fetch_count), .o_stall_count(o_stall_count),
`endif
    .o_halted(o_halted)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: "booted" is false only in the first cycle after reset.
  bit          m_booted, m_halted, m_valid;
  int unsigned m_pc, m_pcn, m_fetch, m_stall;
  logic [31:0] m_instr;

  function automatic void model_reset();
    m_booted = 0; m_halted = 0; m_valid = 0;
    m_pc = 0; m_instr = 32'h0; m_pcn = 0; m_fetch = 0; m_stall = 0;
  endfunction

  function automatic void model_bubble();
    m_valid = 0; m_instr = 32'h0;
  endfunction

  // One clock edge worth of behaviour given the inputs presented before it.
  function automatic void model_step(bit rst, bit st, bit fl, bit br, logic [31:0] tg);
    if (rst) begin model_reset(); return; end
    if (st && !br) m_stall++;
    if (!m_booted) begin
      m_booted = 1; model_bubble();
    end else if (m_halted) begin
      model_bubble();
      if (br) begin m_pc = tg % DEPTH; m_halted = 0; end
    end else if (br) begin
      m_pc = tg % DEPTH; model_bubble();
    end else if (st) begin
      if (fl) model_bubble();
    end else begin
      if (fl) model_bubble();
      else begin
        m_instr = mem[m_pc]; m_pcn = m_pc + 1; m_valid = 1; m_fetch++;
      end
      if (m_pc == DEPTH - 1) m_halted = 1;
      else m_pc = m_pc + 1;
    end
  endfunction

  task automatic compare_all();
    chk("pc", o_pc, m_pc);
    chk("valid", {31'b0, o_ifid_valid}, {31'b0, m_valid});
    chk("instr", o_ifid_instr, m_instr);
    if (m_valid) chk("pc_next", o_ifid_pc_next, m_pcn);
    chk("halted", {31'b0, o_halted}, {31'b0, m_halted});
`ifdef FETCH_PERF_EN
    chk("fetch_count", o_fetch_count, m_fetch);
    chk("stall_count", o_stall_count, m_stall);
`endif
  endtask

  // Present inputs after the falling edge, advance one clock, compare #1 later.
  task automatic step(input bit rst, input bit st, input bit fl, input bit br,
                      input logic [31:0] tg);
    @(negedge clk);
    reset = rst; i_stall = st; i_flush = fl; i_branch_taken = br; i_branch_target = tg;
    model_step(rst, st, fl, br, tg);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'h1000_0000 + k;
    reset = 1; i_stall = 0; i_flush = 0; i_branch_taken = 0; i_branch_target = 0;
    model_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 32'd9);

    // Boot, then run up to o_pc=5 and stall three cycles there.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    chk("dir_pc5", o_pc, 32'd5);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("dir_stall_hold", o_ifid_instr, 32'h1000_0004);
`ifdef FETCH_PERF_EN
    chk("dir_stall_cnt", o_stall_count, 32'd3);
`endif
    step(0, 0, 0, 0, 0);
    chk("dir_resume", o_ifid_instr, 32'h1000_0005);

    // Branch overriding a stall at o_pc=7.
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'd20);
    chk("dir_br_pc", o_pc, 32'd20);
    step(0, 0, 0, 0, 0);
    chk("dir_br_pcn", o_ifid_pc_next, 32'd21);

    // Run into the end of memory, idle halted, then redirect to 3.
    for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0);
    chk("dir_halt", {31'b0, o_halted}, 32'd1);
    step(0, 0, 0, 1, 32'd3);
    chk("dir_unhalt_pc", o_pc, 32'd3);

    // Flush with stall at o_pc=9, then wrap-around redirect target 35 -> 3.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("dir_flush_pc", o_pc, 32'd9);
    step(0, 0, 0, 1, 32'd35);
    chk("dir_wrap_pc", o_pc, 32'd3);

    // Randomized traffic, including occasional mid-run resets.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 25, $urandom_range(99) < 12,
           $urandom_range(99) < 8,
           ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(DEPTH - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
